// File: rtl/mem_io_stage.sv
// Memory/IO stage behind the ALU: word-addressed synchronous data RAM plus a small
// memory-mapped IO window (LEDs, switches, seven-segment register, cycle counter).
module mem_io_stage #(
  parameter int unsigned MEM_ADDR_W = 14,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
  parameter int unsigned LED_W      = 24,
  parameter int unsigned SW_W       = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ALU_Result,
  input  logic [31:0]       Read_data_2,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [SW_W-1:0]   Switch_in,
  output logic [31:0]       Mem_read_data,
  output logic              Mem_stall,
  output logic [LED_W-1:0]  Led_out,
  output logic [31:0]       Seg_data
);

  localparam logic [9:0] OffLed = 10'h060;
  localparam logic [9:0] OffSw  = 10'h070;
  localparam logic [9:0] OffSeg = 10'h080;
  localparam logic [9:0] OffCnt = 10'h090;

  typedef enum logic {StIdle, StWait} state_e;

  state_e                state_q;
  logic [31:0]           mem [1 << MEM_ADDR_W];
  logic [31:0]           ram_rdata_q;
  logic [LED_W-1:0]      led_q;
  logic [31:0]           seg_q;
  logic [31:0]           cnt_q;
  logic [SW_W-1:0]       sw_meta_q;
  logic [SW_W-1:0]       sw_sync_q;

  logic                  is_io;
  logic [MEM_ADDR_W-1:0] ram_idx;
  logic [7:0]            io_word;
  logic                  rd_only;
  logic                  io_wr;
  logic                  ram_wr;
  logic                  load_issue;
  logic [31:0]           io_rdata;
  logic                  unused_addr_bits;

  assign is_io      = (ALU_Result[31:10] == IO_BASE[31:10]);
  assign ram_idx    = ALU_Result[MEM_ADDR_W+1:2];
  assign io_word    = ALU_Result[9:2];
  // A simultaneous store wins; the load half of the request is dropped.
  assign rd_only    = MemRead & ~MemWrite;
  assign io_wr      = MemWrite & is_io;
  assign ram_wr     = MemWrite & ~is_io;
  assign load_issue = (state_q == StIdle) & rd_only & ~is_io & ~reset;

  assign unused_addr_bits = ^ALU_Result[1:0];

  always_ff @(posedge clock) begin
    if (ram_wr && !reset) begin
      mem[ram_idx] <= Read_data_2;
    end
    if (load_issue) begin
      ram_rdata_q <= mem[ram_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= load_issue ? StWait : StIdle;
        StWait:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= '0;
      seg_q     <= '0;
      cnt_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= Switch_in;
      sw_sync_q <= sw_meta_q;
      if (io_wr && io_word == OffLed[9:2]) begin
        led_q <= Read_data_2[LED_W-1:0];
      end
      if (io_wr && io_word == OffSeg[9:2]) begin
        seg_q <= Read_data_2;
      end
      // A counter store replaces this cycle's increment.
      if (io_wr && io_word == OffCnt[9:2]) begin
        cnt_q <= Read_data_2;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    case (io_word)
      OffLed[9:2]: io_rdata = 32'(led_q);
      OffSw[9:2]:  io_rdata = 32'(sw_sync_q);
      OffSeg[9:2]: io_rdata = seg_q;
      OffCnt[9:2]: io_rdata = cnt_q;
      default:     io_rdata = '0;
    endcase
  end

  always_comb begin
    Mem_stall     = 1'b0;
    Mem_read_data = '0;
    if (!reset) begin
      if (state_q == StWait) begin
        Mem_read_data = ram_rdata_q;
      end else if (load_issue) begin
        Mem_stall = 1'b1;
      end else if (rd_only && is_io) begin
        Mem_read_data = io_rdata;
      end
    end
  end

  assign Led_out  = led_q;
  assign Seg_data = seg_q;

endmodule

// File: tb/tb_mem_io_stage.sv
// Bench for mem_io_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of RAM, IO registers and load timing.
module tb_mem_io_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ALU_Result;
  logic [31:0] Read_data_2;
  logic        MemRead;
  logic        MemWrite;
  logic [23:0] Switch_in;
  logic [31:0] Mem_read_data;
  logic        Mem_stall;
  logic [23:0] Led_out;
  logic [31:0] Seg_data;

  int checks   = 0;
  int failures = 0;

  mem_io_stage dut (
    .clock         (clock),
    .reset         (reset),
    .ALU_Result    (ALU_Result),
    .Read_data_2   (Read_data_2),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Switch_in     (Switch_in),
    .Mem_read_data (Mem_read_data),
    .Mem_stall     (Mem_stall),
    .Led_out       (Led_out),
    .Seg_data      (Seg_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [int unsigned];
  logic [31:0] led_m, seg_m, cnt_m, pend_data_m;
  logic [23:0] sw1_m, sw2_m;
  bit          pend_m, pend_known_m;
  bit          armed = 1'b0;

  function automatic bit io_addr(input logic [31:0] a);
    return a[31:10] == 22'h3F_FFFF;
  endfunction

  function automatic int unsigned word_idx(input logic [31:0] a);
    return (a >> 2) % 16384;
  endfunction

  function automatic logic [31:0] io_value(input logic [31:0] a);
    case (a[9:0] & 10'h3FC)
      10'h060: return led_m;
      10'h070: return {8'h00, sw2_m};
      10'h080: return seg_m;
      10'h090: return cnt_m;
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clock);
    if (reset) begin
      led_m = 0; seg_m = 0; cnt_m = 0; sw1_m = 0; sw2_m = 0; pend_m = 0;
      armed = 1'b1;
    end else begin
      logic [31:0] cnt_next;
      sw2_m = sw1_m;
      sw1_m = Switch_in;
      cnt_next = cnt_m + 1;
      if (pend_m) begin
        pend_m = 0;
      end else if (MemRead && !MemWrite && !io_addr(ALU_Result)) begin
        pend_m = 1;
        pend_known_m = mem_m.exists(word_idx(ALU_Result));
        pend_data_m = pend_known_m ? mem_m[word_idx(ALU_Result)] : 32'h0;
      end
      if (MemWrite) begin
        if (io_addr(ALU_Result)) begin
          case (ALU_Result[9:0] & 10'h3FC)
            10'h060: led_m = Read_data_2 & 32'h00FF_FFFF;
            10'h080: seg_m = Read_data_2;
            10'h090: cnt_next = Read_data_2;
            default: ;
          endcase
        end else begin
          mem_m[word_idx(ALU_Result)] = Read_data_2;
        end
      end
      cnt_m = cnt_next;
    end
  end

  // Single per-cycle compare of every output against the model.
  always @(negedge clock) begin
    if (armed) begin
      logic [31:0] exp_rd;
      logic        exp_stall;
      bit          rd_known;
      exp_rd = 0; exp_stall = 0; rd_known = 1;
      if (reset) begin
        exp_rd = 0;
      end else if (pend_m) begin
        exp_rd = pend_data_m;
        rd_known = pend_known_m;
      end else if (MemRead && !MemWrite) begin
        if (io_addr(ALU_Result)) exp_rd = io_value(ALU_Result);
        else exp_stall = 1;
      end
      check("stall", {31'b0, Mem_stall}, {31'b0, exp_stall});
      if (rd_known) check("rdata", Mem_read_data, exp_rd);
      check("led", {8'h00, Led_out}, led_m);
      check("seg", Seg_data, seg_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d);
    @(posedge clock);
    #1;
    reset = r; MemRead = rd; MemWrite = wr; ALU_Result = a; Read_data_2 = d;
    @(negedge clock);
  endtask

  logic [31:0] io_offs [6];

  initial begin
    io_offs[0] = 32'h060; io_offs[1] = 32'h070; io_offs[2] = 32'h080;
    io_offs[3] = 32'h090; io_offs[4] = 32'h000; io_offs[5] = 32'h3FC;
    reset = 1; MemRead = 0; MemWrite = 0; ALU_Result = 0; Read_data_2 = 0; Switch_in = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_led", {8'h00, Led_out}, 32'h0);
    check("rst_seg", Seg_data, 32'h0);
    check("rst_stall", {31'b0, Mem_stall}, 32'h0);

    // RAM store then stalled load.
    cyc(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 32'h0000_0010, 0);
    check("ld1_stall", {31'b0, Mem_stall}, 32'h1);
    check("ld1_data0", Mem_read_data, 32'h0);
    cyc(0, 1, 0, 32'h0000_0010, 0);
    check("ld1_stall2", {31'b0, Mem_stall}, 32'h0);
    check("ld1_data", Mem_read_data, 32'hDEAD_BEEF);

    // LED store and same-cycle IO load.
    cyc(0, 0, 1, 32'hFFFF_FC60, 32'h00A5_A5A5);
    cyc(0, 1, 0, 32'hFFFF_FC60, 0);
    check("led_out", {8'h00, Led_out}, 32'h00A5_A5A5);
    check("led_rd", Mem_read_data, 32'h00A5_A5A5);
    check("led_stall", {31'b0, Mem_stall}, 32'h0);

    // Switch synchronizer latency.
    Switch_in = 24'h123456;
    cyc(0, 1, 0, 32'hFFFF_FC70, 0);
    check("sw_old", Mem_read_data, 32'h0);
    cyc(0, 1, 0, 32'hFFFF_FC70, 0);
    check("sw_new", Mem_read_data, 32'h0012_3456);

    // Counter load and wrap.
    cyc(0, 0, 1, 32'hFFFF_FC90, 32'hFFFF_FFFE);
    cyc(0, 1, 0, 32'hFFFF_FC90, 0);
    check("cnt0", Mem_read_data, 32'hFFFF_FFFE);
    cyc(0, 1, 0, 32'hFFFF_FC90, 0);
    check("cnt1", Mem_read_data, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 32'hFFFF_FC90, 0);
    check("cnt2", Mem_read_data, 32'h0);

    // Back-to-back RAM loads.
    cyc(0, 0, 1, 32'h20, 32'd1);
    cyc(0, 0, 1, 32'h24, 32'd2);
    cyc(0, 1, 0, 32'h20, 0);
    check("b2b_s0", {31'b0, Mem_stall}, 32'h1);
    check("b2b_d0", Mem_read_data, 32'h0);
    cyc(0, 1, 0, 32'h20, 0);
    check("b2b_s1", {31'b0, Mem_stall}, 32'h0);
    check("b2b_d1", Mem_read_data, 32'h1);
    cyc(0, 1, 0, 32'h24, 0);
    check("b2b_s2", {31'b0, Mem_stall}, 32'h1);
    check("b2b_d2", Mem_read_data, 32'h0);
    cyc(0, 1, 0, 32'h24, 0);
    check("b2b_s3", {31'b0, Mem_stall}, 32'h0);
    check("b2b_d3", Mem_read_data, 32'h2);

    // Read and write together: store wins, no data, no stall.
    cyc(0, 1, 1, 32'h30, 32'h77);
    check("rw_stall", {31'b0, Mem_stall}, 32'h0);
    check("rw_data", Mem_read_data, 32'h0);
    cyc(0, 1, 0, 32'h30, 0);
    cyc(0, 1, 0, 32'h30, 0);
    check("rw_ld", Mem_read_data, 32'h77);

    // Reset during WAIT aborts the load.
    cyc(0, 0, 1, 32'hFFFF_FC60, 32'hFF);
    cyc(0, 1, 0, 32'h10, 0);
    check("ab_led", {8'h00, Led_out}, 32'hFF);
    check("ab_stall", {31'b0, Mem_stall}, 32'h1);
    cyc(1, 1, 0, 32'h10, 0);
    cyc(0, 0, 0, 32'h0, 0);
    check("ab_stall2", {31'b0, Mem_stall}, 32'h0);
    check("ab_data", Mem_read_data, 32'h0);
    check("ab_led0", {8'h00, Led_out}, 32'h0);
    cyc(0, 1, 0, 32'h10, 0);
    cyc(0, 1, 0, 32'h10, 0);
    check("ab_ram", Mem_read_data, 32'hDEAD_BEEF);

    // Populate the random address pool, then random traffic.
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 32'(i) << 2, $urandom);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a_ram, a_io, d;
      int k;
      if ($urandom_range(0, 3) == 0) Switch_in = 24'($urandom);
      a_ram = (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      a_io  = 32'hFFFF_FC00 | io_offs[$urandom_range(0, 5)];
      d     = $urandom;
      k     = $urandom_range(0, 9);
      case (k)
        0:       cyc(0, 0, 0, a_ram, d);
        1, 2:    cyc(0, 0, 1, a_ram, d);
        3, 4: begin
          cyc(0, 1, 0, a_ram, d);
          cyc($urandom_range(0, 15) == 0, 1, 0, a_ram, d);
        end
        5:       cyc(0, 0, 1, a_io, d);
        6, 7:    cyc(0, 1, 0, a_io, d);
        8:       cyc(0, 1, 1, $urandom_range(0, 1) ? a_io : a_ram, d);
        default: cyc($urandom_range(0, 7) == 0, 0, 0, a_ram, d);
      endcase
    end
    cyc(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
